// File: rtl/pair_sort_loader_if.sv
// Handshake bundle between a key source/frame sink and pair_sort_loader.
// master: drives keys, flush and out_ready; slave: the loader itself.
// Frame layout on out_data: [W-1:0]=a1, [2W-1:W]=a2, [3W-1:2W]=b1, [4W-1:3W]=b2.
interface pair_sort_loader_if #(
    parameter int WIDTH = 3,
    parameter int N     = 2
);
    logic                   in_valid;
    logic [WIDTH-1:0]       in_data;
    logic                   in_ready;
    logic                   flush;
    logic                   out_valid;
    logic [2*N*WIDTH-1:0]   out_data;
    logic [2:0]             out_count;
    logic                   out_ready;

    modport master (
        output in_valid, in_data, flush, out_ready,
        input  in_ready, out_valid, out_data, out_count
    );

    modport slave (
        input  in_valid, in_data, flush, out_ready,
        output in_ready, out_valid, out_data, out_count
    );
endinterface

// File: rtl/pair_sort_loader.sv
// Serial-to-parallel loader: collects 4 keys into two ascending-sorted pairs.
// Latency: frame valid the cycle after the 4th accept; >= 5 cycles per frame.
// Backpressure: frame held in HOLD until out_ready; in_ready=0 while holding.
// Optional early frame close via flush when PAIR_LOADER_FLUSH_EN is defined.
module pair_sort_loader #(
    parameter int WIDTH = 3,
    parameter int N     = 2
) (
    input  logic              clk,
    input  logic              rst,
    pair_sort_loader_if.slave bus
);
    localparam int FRAME_W = 2 * N * WIDTH;
    localparam logic [WIDTH-1:0] PAD = '1;

    typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_t;

    state_t           state_q;
    logic [1:0]       slot_q;
    logic [WIDTH-1:0] pend_q;
    logic [WIDTH-1:0] a1_q, a2_q, b1_q, b2_q;
    logic [2:0]       cnt_q;
    logic             in_ready_q;
    logic             out_valid_q;

    logic             accept;
    logic             last_key;
    logic [WIDTH-1:0] lo_key, hi_key;
    logic [WIDTH-1:0] pend_now;
    logic [2:0]       k_now;
    logic             flush_close;
    logic [FRAME_W-1:0] frame;

    // Accept, compare-and-swap against the pending key, and flush qualification.
    // Ties keep the earlier (pending) key in the low position.
    always_comb begin
        accept   = in_ready_q && bus.in_valid;
        last_key = accept && (slot_q == 2'd3);
        if (bus.in_data < pend_q) begin
            lo_key = bus.in_data;
            hi_key = pend_q;
        end else begin
            lo_key = pend_q;
            hi_key = bus.in_data;
        end
        pend_now = accept ? bus.in_data : pend_q;
        k_now    = {1'b0, slot_q} + {2'b00, accept};
`ifdef PAIR_LOADER_FLUSH_EN
        flush_close = in_ready_q && bus.flush && (k_now != 3'd0);
`else
        flush_close = 1'b0;
`endif
    end

`ifndef PAIR_LOADER_FLUSH_EN
    // flush is part of the port set in every build but only acts with the feature on.
    logic unused_flush;
    assign unused_flush = bus.flush;
`endif

    // Loader FSM: FILL collects keys into slots, HOLD presents the frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= FILL;
            slot_q      <= 2'd0;
            pend_q      <= '0;
            a1_q        <= '0;
            a2_q        <= '0;
            b1_q        <= '0;
            b2_q        <= '0;
            cnt_q       <= 3'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                FILL: begin
                    if (accept) begin
                        slot_q <= slot_q + 2'd1;
                        case (slot_q)
                            2'd0: pend_q <= bus.in_data;
                            2'd1: begin
                                a1_q <= lo_key;
                                a2_q <= hi_key;
                            end
                            2'd2: pend_q <= bus.in_data;
                            default: begin
                                b1_q <= lo_key;
                                b2_q <= hi_key;
                            end
                        endcase
                    end
                    if (last_key) begin
                        state_q     <= HOLD;
                        slot_q      <= 2'd0;
                        cnt_q       <= 3'd4;
                        in_ready_q  <= 1'b0;
                        out_valid_q <= 1'b1;
                    end else if (flush_close) begin
                        // Early close: lone pending key goes low, pads fill the rest.
                        state_q     <= HOLD;
                        slot_q      <= 2'd0;
                        cnt_q       <= k_now;
                        in_ready_q  <= 1'b0;
                        out_valid_q <= 1'b1;
                        case (k_now)
                            3'd1: begin
                                a1_q <= pend_now;
                                a2_q <= PAD;
                                b1_q <= PAD;
                                b2_q <= PAD;
                            end
                            3'd2: begin
                                b1_q <= PAD;
                                b2_q <= PAD;
                            end
                            default: begin
                                b1_q <= pend_now;
                                b2_q <= PAD;
                            end
                        endcase
                    end
                end
                default: begin
                    if (bus.out_ready) begin
                        state_q     <= FILL;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign frame         = {b2_q, b1_q, a2_q, a1_q};
    assign bus.out_data  = frame;
    assign bus.out_count = cnt_q;
    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_pair_sort_loader.sv
// Directed bench for pair_sort_loader: table of full frames plus hand sequences
// for backpressure, throughput, mid-frame reset and the flush build option.
module tb_pair_sort_loader;
    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pair_sort_loader_if #(.WIDTH(3), .N(2)) bus ();

    pair_sort_loader #(.WIDTH(3), .N(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [2:0] k0, k1, k2, k3;
        logic [2:0] a1, a2, b1, b2;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Present a key once in_ready is seen, leave it for one clock edge.
    task automatic drive_key(input logic [2:0] k);
        int n = 0;
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) chk("in_ready_wait", {31'd0, bus.in_ready}, 32'd1);
        bus.in_valid = 1'b1;
        bus.in_data  = k;
        @(negedge clk);
    endtask

    task automatic frame4(input logic [2:0] k0, k1, k2, k3);
        drive_key(k0);
        drive_key(k1);
        drive_key(k2);
        drive_key(k3);
        bus.in_valid = 1'b0;
    endtask

    task automatic chk_frame(input string nm, input logic [2:0] a1, a2, b1, b2,
                             input logic [2:0] cnt);
        chk({nm, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
        chk({nm, "_data"},  {20'd0, bus.out_data}, {20'd0, b2, b1, a2, a1});
        chk({nm, "_count"}, {29'd0, bus.out_count}, {29'd0, cnt});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        int   t0;

        vecs[0] = '{k0:3'd5, k1:3'd2, k2:3'd7, k3:3'd1, a1:3'd2, a2:3'd5, b1:3'd1, b2:3'd7};
        vecs[1] = '{k0:3'd3, k1:3'd3, k2:3'd0, k3:3'd0, a1:3'd3, a2:3'd3, b1:3'd0, b2:3'd0};
        vecs[2] = '{k0:3'd0, k1:3'd7, k2:3'd7, k3:3'd0, a1:3'd0, a2:3'd7, b1:3'd0, b2:3'd7};
        vecs[3] = '{k0:3'd4, k1:3'd4, k2:3'd4, k3:3'd4, a1:3'd4, a2:3'd4, b1:3'd4, b2:3'd4};
        vecs[4] = '{k0:3'd7, k1:3'd6, k2:3'd5, k3:3'd4, a1:3'd6, a2:3'd7, b1:3'd4, b2:3'd5};
        vecs[5] = '{k0:3'd1, k1:3'd2, k2:3'd3, k3:3'd4, a1:3'd1, a2:3'd2, b1:3'd3, b2:3'd4};

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = 3'd0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        chk("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_out_data",  {20'd0, bus.out_data},  32'd0);
        chk("rst_out_count", {29'd0, bus.out_count}, 32'd0);

        // Table of full frames, sink always ready.
        for (int i = 0; i < 6; i++) begin
            frame4(vecs[i].k0, vecs[i].k1, vecs[i].k2, vecs[i].k3);
            chk_frame($sformatf("vec%0d", i), vecs[i].a1, vecs[i].a2, vecs[i].b1,
                      vecs[i].b2, 3'd4);
            if (i == 0) chk("vec0_packed", {20'd0, bus.out_data}, 32'hE6A);
        end

        // Backpressure: frame held stable for 3 cycles.
        @(negedge clk);
        bus.out_ready = 1'b0;
        frame4(3'd5, 3'd2, 3'd7, 3'd1);
        for (int j = 0; j < 3; j++) begin
            chk($sformatf("hold%0d_data", j), {20'd0, bus.out_data}, 32'hE6A);
            chk($sformatf("hold%0d_in_ready", j), {31'd0, bus.in_ready}, 32'd0);
            chk($sformatf("hold%0d_valid", j), {31'd0, bus.out_valid}, 32'd1);
            chk($sformatf("hold%0d_count", j), {29'd0, bus.out_count}, 32'd4);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("release_in_ready", {31'd0, bus.in_ready},  32'd1);
        chk("release_valid",    {31'd0, bus.out_valid}, 32'd0);

        // Back-to-back frames: 5 cycles from one frame to the next.
        frame4(3'd3, 3'd3, 3'd0, 3'd0);
        chk_frame("b2b_first", 3'd3, 3'd3, 3'd0, 3'd0, 3'd4);
        t0 = cyc;
        frame4(3'd6, 3'd1, 3'd2, 3'd5);
        chk_frame("b2b_second", 3'd1, 3'd6, 3'd2, 3'd5, 3'd4);
        chk("b2b_period", cyc - t0, 32'd5);

        // Reset mid-frame discards the partial frame.
        @(negedge clk);
        drive_key(3'd6);
        drive_key(3'd5);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("midrst_data",  {20'd0, bus.out_data},  32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        frame4(3'd1, 3'd0, 3'd3, 3'd2);
        chk_frame("after_rst", 3'd0, 3'd1, 3'd2, 3'd3, 3'd4);
        @(negedge clk);

`ifdef PAIR_LOADER_FLUSH_EN
        // Three keys then a bare flush: b2 padded.
        drive_key(3'd6);
        drive_key(3'd4);
        drive_key(3'd2);
        bus.in_valid = 1'b0;
        bus.flush    = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        chk_frame("flush3", 3'd4, 3'd6, 3'd2, 3'd7, 3'd3);
        @(negedge clk);
        // Flush on an empty frame does nothing.
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        chk("flush_empty_valid", {31'd0, bus.out_valid}, 32'd0);
        @(negedge clk);
        chk("flush_empty_valid2", {31'd0, bus.out_valid}, 32'd0);
        // Flush together with the first key.
        bus.in_valid = 1'b1;
        bus.in_data  = 3'd5;
        bus.flush    = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        chk_frame("flush1", 3'd5, 3'd7, 3'd7, 3'd7, 3'd1);
        @(negedge clk);
        // Flush together with the second key.
        drive_key(3'd3);
        bus.in_data = 3'd1;
        bus.flush   = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        chk_frame("flush2", 3'd1, 3'd3, 3'd7, 3'd7, 3'd2);
        @(negedge clk);
`else
        // Flush ignored: no frame after 2 keys, 2 more complete a full frame.
        drive_key(3'd4);
        drive_key(3'd6);
        bus.in_valid = 1'b0;
        bus.flush    = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        chk("noflush_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("noflush_in_ready", {31'd0, bus.in_ready}, 32'd1);
        drive_key(3'd7);
        drive_key(3'd3);
        bus.in_valid = 1'b0;
        chk_frame("noflush_frame", 3'd4, 3'd6, 3'd3, 3'd7, 3'd4);
        @(negedge clk);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pair_sort_loader.md
# pair_sort_loader

Serial-to-parallel front end for the 4-key odd-even merge stage. Accepts one WIDTH-bit unsigned key per cycle over a valid/ready handshake and assembles a 4-key frame whose two halves are each sorted ascending. It presents the frame with a valid/ready handshake, packed exactly as the downstream 2-to-4 merge expects. The frame is held stable until the merge side consumes it.

## Interface
- WIDTH, 3, key width in bits (unsigned)
- N, 2, keys per sorted pair; frame holds 2*N keys (only N=2 supported)

- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  in_data carries a key
- in_data  input  WIDTH  incoming key
- in_ready  output  1  loader can accept a key this cycle
- flush  input  1  close the current partial frame (see Configuration)
- out_valid  output  1  out_data holds a complete frame
- out_data  output  2*N*WIDTH  [W-1:0]=a1, [2W-1:W]=a2, [3W-1:2W]=b1, [4W-1:3W]=b2
- out_count  output  3  number of real (non-pad) keys in the frame, 1..4
- out_ready  input  1  downstream consumes the frame

## Operation
- States: FILL (collecting), HOLD (frame presented).
- FILL: in_ready=1. A key is accepted when in_valid&&in_ready. A 2-bit slot counter selects slots 0..3.
- Slot 0: key stored as pending a. Slot 1: compare-and-swap against pending. The smaller key is written to a1, the larger to a2.
- Slots 2/3: same procedure into b1/b2.
- Compare is unsigned. On ties the earlier-arrived key goes to the lower position (stable).
- The 4th accept moves to HOLD, with out_count=4 and the slot counter back at 0.
- HOLD: in_ready=0, out_valid=1. out_data and out_count stay constant while out_ready=0.
- out_valid&&out_ready in HOLD: next cycle FILL, out_valid=0.
- rst (any time, including mid-frame or mid-HOLD): state FILL, slot counter 0, all key registers 0. Any partial frame is discarded.
- Reset values: in_ready=1 (after deassert), out_valid=0, out_data=0, out_count=0.

## Timing
- Latency: the frame is visible (out_valid=1) the cycle after the 4th key is accepted.
- Outputs are registered. in_ready is a function of state only, with no combinational path from out_ready.
- The handshake cycle counts: minimum 5 cycles per frame (4 accepts plus 1 HOLD cycle with out_ready=1).
- in_valid while in_ready=0 is ignored; the source must hold the key.

## Configuration
- PAIR_LOADER_FLUSH_EN defined:
  - flush asserted in FILL with k≥1 keys accepted (counting a key accepted in the same cycle) closes the frame.
  - Empty slots are filled with the pad value, all ones ({WIDTH{1'b1}}), so pads sort to the top of each pair.
  - A single pending key in a pair goes to the low position, with the pad in the high position.
  - out_count=k. The next cycle is HOLD.
  - flush with k=0, or flush in HOLD, has no effect.
- PAIR_LOADER_FLUSH_EN undefined: the flush port exists but is ignored. Only full 4-key frames are produced, and out_count is always 4.

## Test plan
- Keys 5,2,7,1 with out_ready=1 → one cycle after the 4th accept, a1=2, a2=5, b1=1, b2=7; out_count=4; out_data=12'b111_001_101_010.
- Same keys with out_ready held 0 for 3 cycles → out_data constant, in_ready=0 throughout; in_ready=1 one cycle after out_ready rises.
- Ties: keys 3,3,0,0 → a1=a2=3, b1=b2=0; back-to-back frames sustain one frame per 5 cycles.
- Flush enabled: keys 6,4,2 then flush asserted with no key → a1=4, a2=6, b1=2, b2=7 (pad); out_count=3. flush on an empty frame → out_valid stays 0.
- rst pulsed after 2 keys accepted → out_valid=0, out_data=0; the next 4 keys 1,0,3,2 produce a1=0, a2=1, b1=2, b2=3 with no stale data.
- Flush disabled build: flush asserted after 2 keys → no frame emitted; 2 more keys complete a normal frame with out_count=4.
